// File: rtl/line_window_cache.sv
// 3x3 pixel neighbourhood cache over a ring of four captured lines.
// Window outputs appear one pxlClk after curPxl/rdLine. Writes that would overrun the read window are dropped and flagged.
module line_window_cache #(
  parameter int LINE_PXLS   = 240,
  parameter int FRAME_LINES = 160
) (
  input  logic       pxlClk,
  input  logic       rst,
  input  logic       wrFrameStart,
  input  logic       wrValid,
  input  logic [7:0] wrRed,
  input  logic [7:0] wrGreen,
  input  logic [7:0] wrBlue,
  input  logic       nextLine,
  input  logic       cacheUpdate,
  input  logic [7:0] curPxl,
  output logic [7:0] prevLinePrevPxlRed,
  output logic [7:0] prevLinePrevPxlGreen,
  output logic [7:0] prevLinePrevPxlBlue,
  output logic [7:0] prevLineCurPxlRed,
  output logic [7:0] prevLineCurPxlGreen,
  output logic [7:0] prevLineCurPxlBlue,
  output logic [7:0] prevLineNextPxlRed,
  output logic [7:0] prevLineNextPxlGreen,
  output logic [7:0] prevLineNextPxlBlue,
  output logic [7:0] curLinePrevPxlRed,
  output logic [7:0] curLinePrevPxlGreen,
  output logic [7:0] curLinePrevPxlBlue,
  output logic [7:0] curLineCurPxlRed,
  output logic [7:0] curLineCurPxlGreen,
  output logic [7:0] curLineCurPxlBlue,
  output logic [7:0] curLineNextPxlRed,
  output logic [7:0] curLineNextPxlGreen,
  output logic [7:0] curLineNextPxlBlue,
  output logic [7:0] nextLinePrevPxlRed,
  output logic [7:0] nextLinePrevPxlGreen,
  output logic [7:0] nextLinePrevPxlBlue,
  output logic [7:0] nextLineCurPxlRed,
  output logic [7:0] nextLineCurPxlGreen,
  output logic [7:0] nextLineCurPxlBlue,
  output logic [7:0] nextLineNextPxlRed,
  output logic [7:0] nextLineNextPxlGreen,
  output logic [7:0] nextLineNextPxlBlue,
  output logic       sameLine,
  output logic       newFrame,
  output logic       overflow
);

  localparam int LW = $clog2(FRAME_LINES + 1);
  localparam int PW = (LINE_PXLS > 1) ? $clog2(LINE_PXLS) : 1;

  logic [PW-1:0] wr_pxl;
  logic [LW-1:0] wr_line;
  logic [LW-1:0] rd_line;
  logic          new_frame_q;
  logic [23:0]   mem [4][LINE_PXLS];
  logic [23:0]   win [9];

  logic [PW-1:0] base_pxl;
  logic [LW-1:0] base_line;
  logic [LW-1:0] line_inc;
  logic [LW-1:0] rd_next;
  logic          wr_allowed;
  logic          wr_hit;
  logic          line_done;
  logic          nf_rise;
  logic [PW-1:0] c_pxl;
  logic [1:0]    slot [3];
  logic [PW-1:0] pix [3];

  always_comb begin
    // A frame start restarts the write position before the coincident pixel lands.
    base_pxl   = wrFrameStart ? '0 : wr_pxl;
    base_line  = wrFrameStart ? '0 : wr_line;
    wr_allowed = wrValid && (base_line != LW'(FRAME_LINES));
    wr_hit     = wr_allowed && ({1'b0, base_line} != ({1'b0, rd_line} + (LW+1)'(3)));
    line_done  = wr_hit && (base_pxl == PW'(LINE_PXLS - 1));
    line_inc   = base_line + LW'(1);
    nf_rise    = newFrame && !new_frame_q;
    if (nf_rise)
      rd_next = '0;
    else if (nextLine && (rd_line != LW'(FRAME_LINES - 1)))
      rd_next = rd_line + LW'(1);
    else
      rd_next = rd_line;

    c_pxl  = ({1'b0, curPxl} >= 9'(LINE_PXLS)) ? PW'(LINE_PXLS - 1) : PW'(curPxl);
    pix[0] = (c_pxl == '0) ? c_pxl : c_pxl - PW'(1);
    pix[1] = c_pxl;
    pix[2] = (c_pxl == PW'(LINE_PXLS - 1)) ? c_pxl : c_pxl + PW'(1);
    slot[0] = (rd_line == '0) ? rd_line[1:0] : rd_line[1:0] - 2'd1;
    slot[1] = rd_line[1:0];
    slot[2] = (rd_line == LW'(FRAME_LINES - 1)) ? rd_line[1:0] : rd_line[1:0] + 2'd1;
  end

  always_ff @(posedge pxlClk) begin
    if (!rst && wr_hit)
      mem[base_line[1:0]][base_pxl] <= {wrRed, wrGreen, wrBlue};
  end

  always_ff @(posedge pxlClk) begin
    if (rst) begin
      wr_pxl      <= '0;
      wr_line     <= '0;
      rd_line     <= '0;
      overflow    <= 1'b0;
      newFrame    <= 1'b0;
      new_frame_q <= 1'b0;
      sameLine    <= 1'b1;
      for (int i = 0; i < 9; i++) win[i] <= '0;
    end else begin
      if (wr_hit) begin
        wr_pxl  <= line_done ? '0 : base_pxl + PW'(1);
        wr_line <= line_done ? line_inc : base_line;
      end else begin
        wr_pxl  <= base_pxl;
        wr_line <= base_line;
      end
      if (wr_allowed && !wr_hit)
        overflow <= 1'b1;
      if (line_done && (32'(line_inc) == 2))
        newFrame <= 1'b1;
      else if ((line_done && (32'(line_inc) == 8)) || wrFrameStart)
        newFrame <= 1'b0;
      new_frame_q <= newFrame;
      rd_line     <= rd_next;
      if (cacheUpdate)
        sameLine <= ({1'b0, wr_line} <= ({1'b0, rd_next} + (LW+1)'(1)));
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          win[3*i+j] <= mem[slot[i]][pix[j]];
    end
  end

  assign {prevLinePrevPxlRed, prevLinePrevPxlGreen, prevLinePrevPxlBlue} = win[0];
  assign {prevLineCurPxlRed,  prevLineCurPxlGreen,  prevLineCurPxlBlue}  = win[1];
  assign {prevLineNextPxlRed, prevLineNextPxlGreen, prevLineNextPxlBlue} = win[2];
  assign {curLinePrevPxlRed,  curLinePrevPxlGreen,  curLinePrevPxlBlue}  = win[3];
  assign {curLineCurPxlRed,   curLineCurPxlGreen,   curLineCurPxlBlue}   = win[4];
  assign {curLineNextPxlRed,  curLineNextPxlGreen,  curLineNextPxlBlue}  = win[5];
  assign {nextLinePrevPxlRed, nextLinePrevPxlGreen, nextLinePrevPxlBlue} = win[6];
  assign {nextLineCurPxlRed,  nextLineCurPxlGreen,  nextLineCurPxlBlue}  = win[7];
  assign {nextLineNextPxlRed, nextLineNextPxlGreen, nextLineNextPxlBlue} = win[8];

endmodule

// File: tb/tb_line_window_cache.sv
// Directed and random bench for line_window_cache against a pixel-array reference model.
module tb_line_window_cache;
  localparam int LP = 240;
  localparam int FL = 160;

  logic pxlClk = 1'b0;
  logic rst, wrFrameStart, wrValid, nextLine, cacheUpdate;
  logic [7:0] wrRed, wrGreen, wrBlue, curPxl;
  logic [7:0] prevLinePrevPxlRed, prevLinePrevPxlGreen, prevLinePrevPxlBlue;
  logic [7:0] prevLineCurPxlRed, prevLineCurPxlGreen, prevLineCurPxlBlue;
  logic [7:0] prevLineNextPxlRed, prevLineNextPxlGreen, prevLineNextPxlBlue;
  logic [7:0] curLinePrevPxlRed, curLinePrevPxlGreen, curLinePrevPxlBlue;
  logic [7:0] curLineCurPxlRed, curLineCurPxlGreen, curLineCurPxlBlue;
  logic [7:0] curLineNextPxlRed, curLineNextPxlGreen, curLineNextPxlBlue;
  logic [7:0] nextLinePrevPxlRed, nextLinePrevPxlGreen, nextLinePrevPxlBlue;
  logic [7:0] nextLineCurPxlRed, nextLineCurPxlGreen, nextLineCurPxlBlue;
  logic [7:0] nextLineNextPxlRed, nextLineNextPxlGreen, nextLineNextPxlBlue;
  logic sameLine, newFrame, overflow;

  int total = 0;
  int bad = 0;

  // Reference state: captured pixels per slot plus which entries have ever been written.
  logic [23:0] m_mem [4][LP];
  bit          m_known [4][LP];
  int m_wp, m_wl, m_rd;
  bit m_over, m_nf, m_nf_prev, m_same;

  line_window_cache #(.LINE_PXLS(LP), .FRAME_LINES(FL)) dut (
    .pxlClk(pxlClk), .rst(rst), .wrFrameStart(wrFrameStart), .wrValid(wrValid),
    .wrRed(wrRed), .wrGreen(wrGreen), .wrBlue(wrBlue),
    .nextLine(nextLine), .cacheUpdate(cacheUpdate), .curPxl(curPxl),
    .prevLinePrevPxlRed(prevLinePrevPxlRed), .prevLinePrevPxlGreen(prevLinePrevPxlGreen), .prevLinePrevPxlBlue(prevLinePrevPxlBlue),
    .prevLineCurPxlRed(prevLineCurPxlRed), .prevLineCurPxlGreen(prevLineCurPxlGreen), .prevLineCurPxlBlue(prevLineCurPxlBlue),
    .prevLineNextPxlRed(prevLineNextPxlRed), .prevLineNextPxlGreen(prevLineNextPxlGreen), .prevLineNextPxlBlue(prevLineNextPxlBlue),
    .curLinePrevPxlRed(curLinePrevPxlRed), .curLinePrevPxlGreen(curLinePrevPxlGreen), .curLinePrevPxlBlue(curLinePrevPxlBlue),
    .curLineCurPxlRed(curLineCurPxlRed), .curLineCurPxlGreen(curLineCurPxlGreen), .curLineCurPxlBlue(curLineCurPxlBlue),
    .curLineNextPxlRed(curLineNextPxlRed), .curLineNextPxlGreen(curLineNextPxlGreen), .curLineNextPxlBlue(curLineNextPxlBlue),
    .nextLinePrevPxlRed(nextLinePrevPxlRed), .nextLinePrevPxlGreen(nextLinePrevPxlGreen), .nextLinePrevPxlBlue(nextLinePrevPxlBlue),
    .nextLineCurPxlRed(nextLineCurPxlRed), .nextLineCurPxlGreen(nextLineCurPxlGreen), .nextLineCurPxlBlue(nextLineCurPxlBlue),
    .nextLineNextPxlRed(nextLineNextPxlRed), .nextLineNextPxlGreen(nextLineNextPxlGreen), .nextLineNextPxlBlue(nextLineNextPxlBlue),
    .sameLine(sameLine), .newFrame(newFrame), .overflow(overflow)
  );

  always #5 pxlClk = ~pxlClk;

  function automatic logic [215:0] dut_win();
    return {prevLinePrevPxlRed, prevLinePrevPxlGreen, prevLinePrevPxlBlue,
            prevLineCurPxlRed, prevLineCurPxlGreen, prevLineCurPxlBlue,
            prevLineNextPxlRed, prevLineNextPxlGreen, prevLineNextPxlBlue,
            curLinePrevPxlRed, curLinePrevPxlGreen, curLinePrevPxlBlue,
            curLineCurPxlRed, curLineCurPxlGreen, curLineCurPxlBlue,
            curLineNextPxlRed, curLineNextPxlGreen, curLineNextPxlBlue,
            nextLinePrevPxlRed, nextLinePrevPxlGreen, nextLinePrevPxlBlue,
            nextLineCurPxlRed, nextLineCurPxlGreen, nextLineCurPxlBlue,
            nextLineNextPxlRed, nextLineNextPxlGreen, nextLineNextPxlBlue};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: predict from the pre-edge state and inputs, advance the model, then check.
  task automatic tick();
    int cp, wp, wl, k;
    int pix[3];
    int lin[3];
    logic [215:0] ew, em;
    bit rise;
    if (rst) begin
      ew = '0; em = '1;
      m_wp = 0; m_wl = 0; m_rd = 0; m_over = 0; m_nf = 0; m_nf_prev = 0; m_same = 1;
    end else begin
      cp = (int'(curPxl) >= LP) ? LP - 1 : int'(curPxl);
      pix[0] = (cp == 0) ? 0 : cp - 1;
      pix[1] = cp;
      pix[2] = (cp == LP - 1) ? cp : cp + 1;
      lin[0] = (m_rd == 0) ? 0 : m_rd - 1;
      lin[1] = m_rd;
      lin[2] = (m_rd == FL - 1) ? m_rd : m_rd + 1;
      ew = '0; em = '0;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++) begin
          k = i * 3 + j;
          ew[(8-k)*24 +: 24] = m_mem[lin[i] % 4][pix[j]];
          em[(8-k)*24 +: 24] = m_known[lin[i] % 4][pix[j]] ? 24'hFFFFFF : 24'h0;
        end
      rise = m_nf && !m_nf_prev;
      m_nf_prev = m_nf;
      wp = wrFrameStart ? 0 : m_wp;
      wl = wrFrameStart ? 0 : m_wl;
      if (wrFrameStart) m_nf = 0;
      if (wrValid && wl != FL) begin
        if (wl == m_rd + 3) m_over = 1;
        else begin
          m_mem[wl % 4][wp] = {wrRed, wrGreen, wrBlue};
          m_known[wl % 4][wp] = 1;
          wp++;
          if (wp == LP) begin
            wp = 0;
            wl++;
            if (wl == 2) m_nf = 1;
            else if (wl == 8) m_nf = 0;
          end
        end
      end
      if (rise) m_rd = 0;
      else if (nextLine && m_rd < FL - 1) m_rd++;
      if (cacheUpdate) m_same = (m_wl <= m_rd + 1);
      m_wp = wp; m_wl = wl;
    end
    @(posedge pxlClk);
    #1;
    total++;
    assert ((dut_win() & em) === (ew & em)) else begin
      bad++;
      $error("FAIL window observed=%h expected=%h", dut_win() & em, ew & em);
    end
    chk("sameLine", sameLine, m_same);
    chk("newFrame", newFrame, m_nf);
    chk("overflow", overflow, m_over);
  endtask

  task automatic write_pixels(input int line, input int n);
    for (int p = 0; p < n; p++) begin
      wrValid = 1; wrRed = 8'(p); wrGreen = 8'(line); wrBlue = 8'(p ^ (line << 4));
      tick();
    end
    wrValid = 0;
  endtask

  initial begin
    rst = 1; wrFrameStart = 0; wrValid = 0; nextLine = 0; cacheUpdate = 0;
    wrRed = 0; wrGreen = 0; wrBlue = 0; curPxl = 0;
    tick(); tick();
    chk("rst_sameLine", sameLine, 1);
    chk("rst_curRed", curLineCurPxlRed, 0);
    rst = 0;

    // Fill lines 0..2 of a frame.
    wrFrameStart = 1; tick(); wrFrameStart = 0;
    write_pixels(0, LP);
    chk("fill_nf_line0", newFrame, 0);
    write_pixels(1, LP);
    chk("fill_nf_line1", newFrame, 1);
    write_pixels(2, LP);
    cacheUpdate = 1; tick(); cacheUpdate = 0;
    chk("stall_rd0", sameLine, 0);

    // Window edges at rdLine 0.
    curPxl = 0; tick();
    chk("edge_prevLine_green", prevLinePrevPxlGreen, 0);
    chk("edge_prevPxl_red", curLinePrevPxlRed, 0);
    chk("edge_nextPxl_red", curLineNextPxlRed, 1);
    chk("edge_nextLine_green", nextLineCurPxlGreen, 1);
    curPxl = 239; tick();
    chk("edge_239_next", curLineNextPxlRed, 239);
    chk("edge_239_prev", curLinePrevPxlRed, 238);
    curPxl = 250; tick();
    chk("clamp_cur", curLineCurPxlRed, 239);

    // Interior window at rdLine 1.
    nextLine = 1; tick(); nextLine = 0;
    curPxl = 5; tick();
    chk("win_prevG", prevLineCurPxlGreen, 0);
    chk("win_curNextR", curLineNextPxlRed, 6);
    chk("win_nextPrevR", nextLinePrevPxlRed, 4);
    chk("win_nextCurG", nextLineCurPxlGreen, 2);
    chk("win_nextNextG", nextLineNextPxlGreen, 2);

    // Stall flag uses the post-nextLine read line.
    nextLine = 1; cacheUpdate = 1; tick(); nextLine = 0; cacheUpdate = 0;
    chk("stall_rd2", sameLine, 1);
    write_pixels(3, LP);
    cacheUpdate = 1; tick(); cacheUpdate = 0;
    chk("stall_released", sameLine, 0);

    // Overrun with the read line pinned at 0 by the frame-top edge.
    wrFrameStart = 1; tick(); wrFrameStart = 0;
    write_pixels(0, LP);
    write_pixels(1, LP);
    write_pixels(2, LP);
    wrValid = 1; wrRed = 8'hAA; wrGreen = 8'hBB; wrBlue = 8'hCC; tick(); wrValid = 0;
    chk("ovf_set", overflow, 1);
    nextLine = 1; tick(); tick(); nextLine = 0;
    curPxl = 0; tick();
    chk("ovf_slot3_green", nextLineCurPxlGreen, 3);
    chk("ovf_slot3_red", nextLineCurPxlRed, 0);
    wrFrameStart = 1; tick(); wrFrameStart = 0;
    chk("ovf_sticky", overflow, 1);

    // Reset in the middle of a line.
    write_pixels(0, 100);
    rst = 1; wrValid = 1; wrRed = 8'h55; tick(); rst = 0; wrValid = 0;
    chk("mrst_sameLine", sameLine, 1);
    chk("mrst_overflow", overflow, 0);
    chk("mrst_newFrame", newFrame, 0);
    chk("mrst_nextNextB", nextLineNextPxlBlue, 0);
    wrValid = 1; wrRed = 8'h12; wrGreen = 8'h34; wrBlue = 8'h56; tick(); wrValid = 0;
    curPxl = 0; tick();
    chk("mrst_addr0_red", curLineCurPxlRed, 8'h12);
    chk("mrst_addr0_blue", curLineCurPxlBlue, 8'h56);

    // Frame start mid-line with a coincident pixel lands at slot 0 address 0.
    wrFrameStart = 1; wrValid = 1; wrRed = 8'h77; wrGreen = 8'h66; wrBlue = 8'h55; tick();
    wrFrameStart = 0; wrRed = 8'h99; tick(); wrValid = 0;
    tick();
    chk("fs_addr0_red", curLineCurPxlRed, 8'h77);
    curPxl = 1; tick();
    chk("fs_addr1_red", curLineCurPxlRed, 8'h99);

    // Read line saturates at the last frame line.
    nextLine = 1;
    for (int i = 0; i < 170; i++) begin
      curPxl = 8'($urandom_range(0, 255));
      tick();
    end
    nextLine = 0; curPxl = 3; tick();
    chk("sat_prevG", prevLineCurPxlGreen, 2);
    chk("sat_curG", curLineCurPxlGreen, 3);
    chk("sat_nextG", nextLineCurPxlGreen, 3);

    // Random traffic against the model.
    rst = 1; tick(); rst = 0;
    wrFrameStart = 1; tick(); wrFrameStart = 0;
    for (int i = 0; i < 6000; i++) begin
      rst = ($urandom_range(0, 2999) == 0);
      wrFrameStart = ($urandom_range(0, 499) == 0);
      wrValid = ($urandom_range(0, 3) != 0);
      nextLine = ($urandom_range(0, 249) == 0);
      cacheUpdate = ($urandom_range(0, 39) == 0);
      curPxl = 8'($urandom_range(0, 255));
      wrRed = 8'($urandom); wrGreen = 8'($urandom); wrBlue = 8'($urandom);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/line_window_cache.md
LINE_WINDOW_CACHE -- requirements
Module: line_window_cache

Interface
REQ-001 SHALL have parameter LINE_PXLS, default 240, meaning pixels per captured line.
REQ-002 SHALL have parameter FRAME_LINES, default 160, meaning captured lines per frame.
REQ-003 SHALL have ports: pxlClk in 1 pixel clock; rst in 1 reset, synchronous, active-high, clock pxlClk.
REQ-004 SHALL have ports: wrFrameStart in 1 (pulse, new captured frame begins); wrValid in 1; wrRed/wrGreen/wrBlue in 8 each (captured pixel).
REQ-005 SHALL have ports: nextLine in 1 (advance read window); cacheUpdate in 1 (once per output line); curPxl in 8 (read pixel index).
REQ-006 SHALL have 27 outputs {prev,cur,next}Line{Prev,Cur,Next}Pxl{Red,Green,Blue}, 8 bits each: the 3x3 neighbourhood around (rdLine, curPxl).
REQ-007 SHALL have outputs: sameLine out 1 (next line not yet available); newFrame out 1 (frame-top sync level); overflow out 1 (sticky write-overrun flag).

Function
REQ-008 SHALL store lines in a ring of 4 slots of LINE_PXLS x 24 bit, each slot independently readable so three lines are read per cycle.
REQ-009 SHALL keep write pixel counter wrPxl (0..LINE_PXLS-1) and write line counter wrLine (0..FRAME_LINES); wrFrameStart clears both and selects slot 0.
REQ-010 SHALL write {R,G,B} to slot wrLine mod 4, address wrPxl, on each wrValid cycle; wrPxl increments; at LINE_PXLS-1 it wraps to 0 and wrLine increments (line complete).
REQ-011 SHALL ignore wrValid when wrLine == FRAME_LINES (frame complete) until next wrFrameStart.
REQ-012 SHALL drop writes and set overflow when wrLine == rdLine+3 (would overwrite prev-line slot); overflow clears only on rst.
REQ-013 SHALL keep read line rdLine (0..FRAME_LINES-1); nextLine=1 increments rdLine, saturating at FRAME_LINES-1.
REQ-014 SHALL resolve lines: prev = rdLine-1 (rdLine if rdLine==0); next = rdLine+1 (rdLine if rdLine==FRAME_LINES-1).
REQ-015 SHALL resolve pixels: prev = curPxl-1 (0 if curPxl==0); next = curPxl+1 (LINE_PXLS-1 if curPxl==LINE_PXLS-1); curPxl >= LINE_PXLS clamps to LINE_PXLS-1.
REQ-016 SHALL register all 27 window outputs: latency exactly 1 pxlClk from curPxl/rdLine change to output.
REQ-017 SHALL update sameLine only on cycles with cacheUpdate=1, to 1 when wrLine <= rdLine'+1, else 0, where rdLine' is rdLine after any same-cycle nextLine; sameLine holds otherwise.
REQ-018 SHALL set newFrame=1 the cycle wrLine becomes 2 after wrFrameStart; SHALL clear newFrame when wrLine becomes 8 or on wrFrameStart.
REQ-019 SHALL force rdLine to 0 on every cycle newFrame is 0->1 (registered edge); this overrides a coincident nextLine.
REQ-020 SHALL, on wrFrameStart coinciding with wrValid, clear counters first and write that pixel to slot 0 address 0.
REQ-021 SHALL, on wrFrameStart mid-line, discard the partial line (counters cleared; no wrLine increment).

Reset
REQ-022 SHALL on rst clear wrPxl, wrLine, rdLine, overflow, newFrame to 0 and set sameLine to 1.
REQ-023 SHALL on rst drive all window outputs to 0 from the following cycle; slot RAM contents need not be cleared.
REQ-024 SHALL ignore all other inputs on cycles where rst=1.

Verification
REQ-025 Fill: wrFrameStart, then 480 wrValid pixels with R=pixel index, G=line -> newFrame 0 after line 0, 1 after line 1 completes; rdLine=0.
REQ-026 Window: lines 0..2 written, rdLine=1, curPxl=5 -> next cycle prevLineCurPxlGreen=0, curLineNextPxlRed=6, nextLinePrevPxlRed=4, nextLine*Green=2.
REQ-027 Edges: rdLine=0, curPxl=0 -> prevLine* equals curLine*, *PrevPxl equals *CurPxl; curPxl=239 -> *NextPxlRed=239.
REQ-028 Stall: wrLine=3, rdLine=2, cacheUpdate=1 -> sameLine=1; write line 3 fully, cacheUpdate -> sameLine=0.
REQ-029 Overrun: rdLine held 0, write 3 full lines then 1 pixel -> overflow=1, slot 3 unchanged, overflow stays 1 after next wrFrameStart.
REQ-030 Reset mid-line: rst at wrPxl=100 -> all outputs 0 next cycle, sameLine=1, next wrValid writes slot 0 address 0.
